// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: request sizes, FSM states and
// the byte-lane selection used by the store merge path.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_e;

    // One bit per little-endian byte lane touched by an access of this size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << addr_lo;
            SIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks the addressed byte/half/word out of a
// d_mem word and sign- or zero-extends it.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata_i >> {addr_lo_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = 32'h0;
        case (size_i)
            SIZE_BYTE: data_o = unsigned_i ? {24'h0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: data_o = unsigned_i ? {16'h0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            SIZE_WORD: data_o = rdata_i;
            default:   data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of the word-addressed d_mem: byte-addressed CPU
// requests become word accesses, with a 2-cycle read-modify-write for sb/sh.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEMORY_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        access_err,
    output logic        err_sticky,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE);

    state_e      state_q;
    logic [31:0] merge_q;
    logic [31:0] merge_d;
    logic [31:0] widx_q;
    logic        err_sticky_q;

    logic [31:0] word_idx;
    logic        in_idle;
    logic        in_rmw;
    logic        any_req;
    logic        bad_req;
    logic        do_load;
    logic        do_word_store;
    logic        do_sub_store;
    logic [3:0]  lanes;
    logic [31:0] bit_mask;
    logic [31:0] wdata_rep;
    logic [31:0] aligned_data;

    assign word_idx = {2'b00, req_addr[31:2]};
    assign in_idle  = (state_q == IDLE);
    assign in_rmw   = (state_q == RMW_WRITE);
    assign any_req  = req_read || req_write;

    always_comb begin
        bad_req = (req_read && req_write)
               || (req_size == 2'b11)
               || ((req_size == SIZE_HALF) && req_addr[0])
               || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
               || (word_idx >= MEM_WORDS);
    end

    assign access_err    = in_idle && any_req && bad_req;
    assign do_load       = in_idle && req_read && !access_err;
    assign do_word_store = in_idle && req_write && !access_err && (req_size == SIZE_WORD);
    assign do_sub_store  = in_idle && req_write && !access_err && (req_size != SIZE_WORD);

    // Sub-word store data is replicated across all lanes so the mask alone picks the target.
    always_comb begin
        lanes     = lane_mask(req_size, req_addr[1:0]);
        bit_mask  = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        wdata_rep = (req_size == SIZE_BYTE) ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};
        merge_d   = (mem_rdata & ~bit_mask) | (wdata_rep & bit_mask);
    end

    load_align u_load_align (
        .rdata_i    (mem_rdata),
        .addr_lo_i  (req_addr[1:0]),
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .data_o     (aligned_data)
    );

    assign mem_read   = do_load || do_sub_store;
    assign mem_write  = do_word_store || in_rmw;
    assign stall      = do_sub_store;
    assign mem_addr   = in_rmw ? widx_q : word_idx;
    assign mem_wdata  = in_rmw ? merge_q : req_wdata;
    assign load_data  = do_load ? aligned_data : 32'h0;
    assign err_sticky = err_sticky_q;

    // The word index is captured with the merged data so the write-back cycle ignores req_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            merge_q      <= 32'h0;
            widx_q       <= 32'h0;
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_q || access_err;
            case (state_q)
                IDLE: begin
                    if (do_sub_store) begin
                        state_q <= RMW_WRITE;
                        merge_q <= merge_d;
                        widx_q  <= word_idx;
                    end
                end
                RMW_WRITE: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a simple 64-word d_mem stand-in.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        access_err;
    logic        err_sticky;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] dmem [0:63] = '{default: 32'h0};

    mem_access_unit #(.MEMORY_SIZE(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .load_data    (load_data),
        .stall        (stall),
        .access_err   (access_err),
        .err_sticky   (err_sticky),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // d_mem behaves like the real one: high-Z read data whenever memRead is low.
    assign mem_rdata = (mem_read && mem_addr < 32'd64) ? dmem[mem_addr[5:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 32'd64)
            dmem[mem_addr[5:0]] <= mem_wdata;
    end

    // Applies a request on the falling edge and lets combinational outputs settle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_read     = rd;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        #1;
    endtask

    task automatic goIdle();
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_read = 1'b0; req_write = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #2;
        tests_run++;
        if ({stall, mem_read, mem_write, access_err, err_sticky} !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes: got %b expected 00000",
                     {stall, mem_read, mem_write, access_err, err_sticky});
        end
        tests_run++;
        if (load_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_load_data: got %h expected 00000000", load_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_access();
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
        tests_run++;
        if ({stall, mem_read, mem_write, mem_addr, mem_wdata} !== {3'b001, 32'd1, 32'h11223344}) begin
            tests_failed++;
            $display("[TB] FAIL sw_strobes: got s%b r%b w%b a%h d%h expected s0 r0 w1 a00000001 d11223344",
                     stall, mem_read, mem_write, mem_addr, mem_wdata);
        end
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        tests_run++;
        if ({stall, mem_read, mem_write, load_data} !== {3'b010, 32'h11223344}) begin
            tests_failed++;
            $display("[TB] FAIL lw_after_sw: got s%b r%b w%b data %h expected s0 r1 w0 data 11223344",
                     stall, mem_read, mem_write, load_data);
        end
    endtask

    task automatic test_subword_store();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AA);
        tests_run++;
        if ({stall, mem_read, mem_write, access_err} !== 4'b1100) begin
            tests_failed++;
            $display("[TB] FAIL sb_first_cycle: got %b expected 1100",
                     {stall, mem_read, mem_write, access_err});
        end
        // Garbage on the request bus proves the write-back uses the captured index.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'hDEADBEEF);
        tests_run++;
        if ({stall, mem_write, mem_addr, mem_wdata} !== {2'b01, 32'd1, 32'h1122AA44}) begin
            tests_failed++;
            $display("[TB] FAIL sb_write_cycle: got s%b w%b a%h d%h expected s0 w1 a00000001 d1122aa44",
                     stall, mem_write, mem_addr, mem_wdata);
        end
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        tests_run++;
        if (load_data !== 32'h1122AA44) begin
            tests_failed++;
            $display("[TB] FAIL lw_after_sb: got %h expected 1122aa44", load_data);
        end
    endtask

    task automatic test_loads();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        tests_run++;
        if (load_data !== 32'hFFFFFFAA) begin
            tests_failed++;
            $display("[TB] FAIL lb_signed: got %h expected ffffffaa", load_data);
        end
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        tests_run++;
        if (load_data !== 32'h000000AA) begin
            tests_failed++;
            $display("[TB] FAIL lbu: got %h expected 000000aa", load_data);
        end
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
        tests_run++;
        if (load_data !== 32'h00000044) begin
            tests_failed++;
            $display("[TB] FAIL lb_lane0: got %h expected 00000044", load_data);
        end
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        tests_run++;
        if (load_data !== 32'h00001122) begin
            tests_failed++;
            $display("[TB] FAIL lh_high: got %h expected 00001122", load_data);
        end
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h00008001);
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tests_run++;
        if ({mem_write, mem_wdata} !== {1'b1, 32'h8001AA44}) begin
            tests_failed++;
            $display("[TB] FAIL sh_merge: got w%b d%h expected w1 d8001aa44", mem_write, mem_wdata);
        end
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        tests_run++;
        if (load_data !== 32'hFFFF8001) begin
            tests_failed++;
            $display("[TB] FAIL lh_signed: got %h expected ffff8001", load_data);
        end
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
        tests_run++;
        if (load_data !== 32'h00008001) begin
            tests_failed++;
            $display("[TB] FAIL lhu: got %h expected 00008001", load_data);
        end
    endtask

    task automatic test_errors();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        tests_run++;
        if ({access_err, mem_read, mem_write, stall, err_sticky, load_data} !== {5'b10000, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL lw_misaligned: got e%b r%b w%b s%b st%b data %h expected e1 r0 w0 s0 st0 data 0",
                     access_err, mem_read, mem_write, stall, err_sticky, load_data);
        end
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h1234);
        tests_run++;
        if ({access_err, mem_read, mem_write, stall, err_sticky} !== 5'b10001) begin
            tests_failed++;
            $display("[TB] FAIL sh_misaligned: got %b expected 10001",
                     {access_err, mem_read, mem_write, stall, err_sticky});
        end
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'd256, 32'h0);
        tests_run++;
        if ({access_err, mem_read, mem_write, load_data} !== {3'b100, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL lw_out_of_range: got e%b r%b w%b data %h expected e1 r0 w0 data 0",
                     access_err, mem_read, mem_write, load_data);
        end
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
        tests_run++;
        if ({access_err, mem_read} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL size_illegal: got %b expected 10", {access_err, mem_read});
        end
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'd252, 32'h0);
        tests_run++;
        if ({access_err, mem_read} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL lw_last_word: got %b expected 01", {access_err, mem_read});
        end
        goIdle();
        goIdle();
        tests_run++;
        if ({err_sticky, access_err, load_data} !== {2'b10, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL sticky_held: got st%b e%b data %h expected st1 e0 data 0",
                     err_sticky, access_err, load_data);
        end
    endtask

    task automatic test_reset_in_rmw();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'hD, 32'h00000055);
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tests_run++;
        if ({stall, mem_write, mem_addr} !== {2'b01, 32'd3}) begin
            tests_failed++;
            $display("[TB] FAIL rmw_pending: got s%b w%b a%h expected s0 w1 a00000003",
                     stall, mem_write, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({stall, mem_write, mem_read} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL rmw_async_drop: got %b expected 000", {stall, mem_write, mem_read});
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        tests_run++;
        if ({stall, err_sticky, load_data} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL rmw_dropped: got s%b st%b data %h expected s0 st0 data 0",
                     stall, err_sticky, load_data);
        end
    endtask

    task automatic test_read_and_write();
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D);
        tests_run++;
        if ({access_err, mem_read, mem_write, stall, load_data} !== {4'b1000, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL rd_and_wr: got e%b r%b w%b s%b data %h expected e1 r0 w0 s0 data 0",
                     access_err, mem_read, mem_write, stall, load_data);
        end
        goIdle();
        tests_run++;
        if ({mem_read, mem_write, load_data} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL idle_load_data: got r%b w%b data %h expected r0 w0 data 0",
                     mem_read, mem_write, load_data);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h00000011);
        tests_run++;
        if ({stall, mem_write} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_read: got %b expected 10", {stall, mem_write});
        end
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h9, 32'h00000022);
        tests_run++;
        if ({stall, mem_write, mem_wdata} !== {2'b01, 32'h00000011}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_write: got s%b w%b d%h expected s0 w1 d00000011",
                     stall, mem_write, mem_wdata);
        end
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h9, 32'h00000022);
        tests_run++;
        if ({stall, mem_write} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_read: got %b expected 10", {stall, mem_write});
        end
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tests_run++;
        if ({stall, mem_write, mem_wdata} !== {2'b01, 32'h00002211}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_write: got s%b w%b d%h expected s0 w1 d00002211",
                     stall, mem_write, mem_wdata);
        end
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        tests_run++;
        if (load_data !== 32'h00002211) begin
            tests_failed++;
            $display("[TB] FAIL b2b_readback: got %h expected 00002211", load_data);
        end
    endtask

    initial begin
        test_reset();
        test_word_access();
        test_subword_store();
        test_loads();
        test_errors();
        test_reset_in_rmw();
        test_read_and_write();
        test_back_to_back();
        goIdle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
